// File: rtl/bus_memory_slave.sv
// bus_memory_slave: burst memory responder for a fixed address window with byte-lane writes.
// Define BUS_SLAVE_ERROR_RESP_EN to answer window hits whose burst runs past the top of memory with bus_errorOUT.
module bus_memory_slave #(
   parameter logic [31:0] Base = 32'h40000000,
   parameter int AddrBits = 9
) (
   input  logic        clock,
   input  logic        n_reset,
   input  logic [31:0] address_dataIN,
   input  logic [3:0]  byte_enableIN,
   input  logic [7:0]  burst_sizeIN,
   input  logic        read_n_writeIN,
   input  logic        begin_transactionIN,
   input  logic        end_transactionIN,
   input  logic        data_validIN,
   input  logic        busyIN,
   output logic [31:0] address_dataOUT,
   output logic        data_validOUT,
   output logic        end_transactionOUT,
   output logic        bus_errorOUT,
   output logic        busyOUT
);
   localparam int Depth = 1 << AddrBits;
   localparam logic [AddrBits-1:0] One = 1;
   typedef enum logic [2:0] {IDLE, WRITE, READ, READ_END, ERROR} state_t;
   state_t state_q, state_d;
   logic [31:0] din_q;
   logic [3:0] be_in_q;
   logic [7:0] bs_q;
   logic rnw_in_q, begin_q, end_q, dv_q;
   logic [AddrBits-1:0] index_q, index_d, start_index;
   logic [3:0] be_q, be_d;
   logic rnw_q, rnw_d;
   logic [8:0] count_q, count_d;
   logic [31:0] data_q, data_d;
   logic valid_q, valid_d, endo_q, endo_d, err_q, err_d;
   logic in_window, overflow, advance, wr_beat;
   logic [31:0] mem [Depth];

   assign start_index = din_q[AddrBits+1:2];
   assign in_window = din_q[31:AddrBits+2] == Base[31:AddrBits+2];
`ifdef BUS_SLAVE_ERROR_RESP_EN
   assign overflow = 32'(start_index) + 32'(bs_q) >= 32'(Depth);
`else
   assign overflow = 1'b0;
`endif
   assign advance = !valid_q || !busyIN;
   assign wr_beat = state_q == WRITE && dv_q && count_q != 9'd0;

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      be_d = be_q;
      rnw_d = rnw_q;
      count_d = count_q;
      data_d = data_q;
      valid_d = valid_q;
      endo_d = 1'b0;
      err_d = 1'b0;
      case (state_q)
         IDLE: if (begin_q && in_window) begin
            index_d = start_index;
            be_d = be_in_q;
            rnw_d = rnw_in_q;
            count_d = 9'(bs_q) + 9'd1;
            err_d = overflow;
            state_d = overflow ? ERROR : (rnw_in_q ? READ : WRITE);
         end
         WRITE: begin
            if (wr_beat) begin
               index_d = index_q + One;
               count_d = count_q - 9'd1;
            end
            if (end_q) state_d = IDLE;
         end
         READ: if (end_q) begin
            data_d = '0;
            valid_d = 1'b0;
            state_d = IDLE;
         end else if (advance) begin
            // counter reaching zero means the last beat has just been accepted
            data_d = count_q != 9'd0 ? mem[index_q] : '0;
            valid_d = count_q != 9'd0;
            endo_d = count_q == 9'd0;
            index_d = count_q != 9'd0 ? index_q + One : index_q;
            count_d = count_q != 9'd0 ? count_q - 9'd1 : count_q;
            state_d = count_q != 9'd0 ? READ : READ_END;
         end
         READ_END: state_d = IDLE;
         ERROR: if (rnw_q) begin
            endo_d = 1'b1;
            state_d = READ_END;
         end else if (end_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      din_q <= address_dataIN;
      be_in_q <= byte_enableIN;
      bs_q <= burst_sizeIN;
      rnw_in_q <= read_n_writeIN;
      index_q <= index_d;
      be_q <= be_d;
      rnw_q <= rnw_d;
      count_q <= count_d;
      if (!n_reset) begin
         begin_q <= 1'b0;
         end_q <= 1'b0;
         dv_q <= 1'b0;
         state_q <= IDLE;
         data_q <= '0;
         valid_q <= 1'b0;
         endo_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         begin_q <= begin_transactionIN;
         end_q <= end_transactionIN;
         dv_q <= data_validIN;
         state_q <= state_d;
         data_q <= data_d;
         valid_q <= valid_d;
         endo_q <= endo_d;
         err_q <= err_d;
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < 4; i++)
         if (n_reset && wr_beat && be_q[i]) mem[index_q][8*i +: 8] <= din_q[8*i +: 8];
   end

   assign address_dataOUT = data_q;
   assign data_validOUT = valid_q;
   assign end_transactionOUT = endo_q;
   assign bus_errorOUT = err_q;
   assign busyOUT = 1'b0;
endmodule

// File: tb/tb_bus_memory_slave.sv
// tb_bus_memory_slave: directed bursts checked every cycle against a cycle-indexed expectation table built from a word-array memory model.
module tb_bus_memory_slave;
   localparam logic [31:0] BASE = 32'h40000000;
   localparam int WORDS = 512;
   localparam int NCYC = 1024;
`ifdef BUS_SLAVE_ERROR_RESP_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   logic clock = 1'b0;
   logic n_reset = 1'b0;
   logic [31:0] address_dataIN = '0;
   logic [3:0] byte_enableIN = '0;
   logic [7:0] burst_sizeIN = '0;
   logic read_n_writeIN = 1'b0, begin_transactionIN = 1'b0, end_transactionIN = 1'b0;
   logic data_validIN = 1'b0, busyIN = 1'b0;
   logic [31:0] address_dataOUT;
   logic data_validOUT, end_transactionOUT, bus_errorOUT, busyOUT;

   bus_memory_slave dut (
      .clock(clock), .n_reset(n_reset), .address_dataIN(address_dataIN),
      .byte_enableIN(byte_enableIN), .burst_sizeIN(burst_sizeIN), .read_n_writeIN(read_n_writeIN),
      .begin_transactionIN(begin_transactionIN), .end_transactionIN(end_transactionIN),
      .data_validIN(data_validIN), .busyIN(busyIN), .address_dataOUT(address_dataOUT),
      .data_validOUT(data_validOUT), .end_transactionOUT(end_transactionOUT),
      .bus_errorOUT(bus_errorOUT), .busyOUT(busyOUT));

   always #5 clock = ~clock;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   logic [31:0] mdl [WORDS];
   logic [31:0] wdata [8];
   logic [31:0] exp_data [NCYC];
   bit exp_valid [NCYC], exp_end [NCYC], exp_err [NCYC];
   logic [31:0] cap_data [NCYC];
   logic cap_valid [NCYC], cap_end [NCYC], cap_err [NCYC];

   task automatic tick;
      @(posedge clock);
      #1 cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   always @(negedge clock) if (cyc >= 1 && cyc < NCYC) begin
      cap_data[cyc] = address_dataOUT;
      cap_valid[cyc] = data_validOUT;
      cap_end[cyc] = end_transactionOUT;
      cap_err[cyc] = bus_errorOUT;
      checks++;
      if ({address_dataOUT, data_validOUT, end_transactionOUT, bus_errorOUT, busyOUT} !==
          {exp_data[cyc], exp_valid[cyc], exp_end[cyc], exp_err[cyc], 1'b0}) begin
         errors++;
         $display("FAIL cycle %0d outputs got data=%h v=%b end=%b err=%b busy=%b want data=%h v=%b end=%b err=%b",
                  cyc, address_dataOUT, data_validOUT, end_transactionOUT, bus_errorOUT, busyOUT,
                  exp_data[cyc], exp_valid[cyc], exp_end[cyc], exp_err[cyc]);
      end
   end

   function automatic bit hit(input logic [31:0] a);
      return a >= BASE && a < BASE + 32'(4 * WORDS);
   endfunction

   task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input int n, output int c);
      int idx;
      c = cyc;
      idx = int'((addr - BASE) >> 2);
      if (hit(addr) && ERR_EN && idx + n > WORDS) exp_err[c+2] = 1'b1;
      else if (hit(addr))
         for (int i = 0; i < n; i++)
            for (int b = 0; b < 4; b++)
               if (be[b]) mdl[(idx + i) % WORDS][8*b +: 8] = wdata[i][8*b +: 8];
      address_dataIN = addr; byte_enableIN = be; burst_sizeIN = 8'(n - 1);
      read_n_writeIN = 1'b0; begin_transactionIN = 1'b1;
      tick;
      begin_transactionIN = 1'b0;
      for (int i = 0; i < n; i++) begin
         address_dataIN = wdata[i]; data_validIN = 1'b1;
         tick;
      end
      data_validIN = 1'b0; address_dataIN = '0; end_transactionIN = 1'b1;
      tick;
      end_transactionIN = 1'b0;
      tick;
      tick;
   endtask

   // busy window [bf,bt] and reset cycle rst_at are offsets from the begin cycle
   task automatic do_read(input logic [31:0] addr, input int n, input int bf, input int bt,
                          input int rst_at, output int c);
      int idx, t;
      c = cyc;
      idx = int'((addr - BASE) >> 2);
      if (hit(addr) && ERR_EN && idx + n > WORDS) begin
         exp_err[c+2] = 1'b1; exp_end[c+3] = 1'b1;
      end else if (hit(addr)) begin
         t = c + 3;
         for (int i = 0; i < n; i++) begin
            exp_valid[t] = 1'b1; exp_data[t] = mdl[(idx + i) % WORDS];
            while (t - c >= bf && t - c <= bt) begin
               t++;
               exp_valid[t] = 1'b1; exp_data[t] = mdl[(idx + i) % WORDS];
            end
            t++;
         end
         exp_end[t] = 1'b1;
      end
      if (rst_at >= 0)
         for (int k = c + rst_at + 1; k < c + n + 16; k++) begin
            exp_valid[k] = 1'b0; exp_data[k] = '0; exp_end[k] = 1'b0; exp_err[k] = 1'b0;
         end
      address_dataIN = addr; byte_enableIN = 4'hF; burst_sizeIN = 8'(n - 1);
      read_n_writeIN = 1'b1; begin_transactionIN = 1'b1;
      tick;
      begin_transactionIN = 1'b0; address_dataIN = '0;
      for (int k = 0; k < n + 12; k++) begin
         busyIN = cyc - c >= bf && cyc - c <= bt;
         n_reset = !(rst_at >= 0 && cyc - c == rst_at);
         tick;
      end
      busyIN = 1'b0; n_reset = 1'b1;
   endtask

   initial begin
      int c;
      logic quiet;
      for (int i = 0; i < NCYC; i++) exp_data[i] = '0;
      tick; tick; tick;
      n_reset = 1'b1;
      tick;
      wdata[0] = 32'h11; wdata[1] = 32'h22; wdata[2] = 32'h33; wdata[3] = 32'h44;
      do_write(32'h40000010, 4'hF, 4, c);
      do_read(32'h40000010, 4, -1, -2, -1, c);
      chk("burst_first", cap_data[c+3], 32'h11);
      chk("burst_last", {cap_valid[c+6], cap_data[c+6]}, {1'b1, 32'h44});
      chk("burst_end", {cap_valid[c+7], cap_end[c+7]}, 2'b01);
      wdata[0] = 32'hFFFFFFFF;
      do_write(32'h40000080, 4'hF, 1, c);
      wdata[0] = 32'hAABBCCDD;
      do_write(32'h40000080, 4'b0101, 1, c);
      do_read(32'h40000080, 1, -1, -2, -1, c);
      chk("byte_lanes", cap_data[c+3], 32'hFFBBFFDD);
      do_read(32'h40000010, 4, 4, 5, -1, c);
      chk("busy_hold", {cap_data[c+4], cap_data[c+6]}, {32'h22, 32'h22});
      chk("busy_next", cap_data[c+7], 32'h33);
      chk("busy_end", cap_end[c+9], 32'h1);
      do_read(32'h50000000, 4, -1, -2, -1, c);
      quiet = 1'b0;
      for (int k = 1; k < 10; k++) quiet = quiet | cap_valid[c+k] | cap_end[c+k] | cap_err[c+k];
      chk("miss_quiet", quiet, 32'h0);
      wdata[0] = 32'hDEADBEEF;
      do_write(32'h50000010, 4'hF, 1, c);
      do_read(32'h40000010, 1, -1, -2, -1, c);
      chk("miss_no_write", cap_data[c+3], 32'h11);
      do_read(32'h40000010, 4, -1, -2, 4, c);
      chk("reset_clear", {cap_valid[c+5], cap_data[c+5]}, 33'h0);
      do_read(32'h40000010, 4, -1, -2, -1, c);
      chk("reset_keep_mem", {cap_data[c+3], cap_data[c+4]}, {32'h11, 32'h22});
      wdata[0] = 32'hA5A5A5A5;
      do_write(32'h400007FC, 4'hF, 1, c);
      wdata[0] = 32'h5A5A5A5A;
      do_write(32'h40000000, 4'hF, 1, c);
      wdata[0] = 32'h12345678; wdata[1] = 32'h9ABCDEF0;
      do_write(32'h400007FC, 4'hF, 2, c);
`ifdef BUS_SLAVE_ERROR_RESP_EN
      chk("wrap_err_pulse", {cap_err[c+2], cap_err[c+3]}, 2'b10);
`endif
      do_read(32'h400007FC, 1, -1, -2, -1, c);
      chk("wrap_word511", cap_data[c+3], ERR_EN ? 32'hA5A5A5A5 : 32'h12345678);
      do_read(32'h40000000, 1, -1, -2, -1, c);
      chk("wrap_word0", cap_data[c+3], ERR_EN ? 32'h5A5A5A5A : 32'h9ABCDEF0);
      do_read(32'h400007FC, 2, -1, -2, -1, c);
      tick;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
